// File: rtl/init_sequencer_if.sv
// ----------------------------------------------------------------------------
// init_sequencer_if
//
// Purpose:
//   Groups the write port and the table lookup port of the initialisation
//   sequencer. The sequencer uses the master modport. The storage arrays and
//   the table ROM use the slave modport.
//
// Parameters:
//   CH_W    width of the channel select
//   ADDR_W  address width of the largest channel
//   DATA_W  write data width of the widest channel
//
// Signals:
//   wr_valid_o  master -> slave  write request valid
//   wr_ready_i  slave -> master  target accepts the write
//   wr_ch_o     master -> slave  channel being written
//   wr_addr_o   master -> slave  address within the channel
//   wr_data_o   master -> slave  write data
//   tbl_addr_o  master -> slave  table lookup address (equals wr_addr_o)
//   tbl_data_i  slave -> master  combinational table data for that address
// ----------------------------------------------------------------------------
interface init_sequencer_if #(
    parameter int CH_W   = 2,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 40
);
    logic              wr_valid_o;
    logic              wr_ready_i;
    logic [CH_W-1:0]   wr_ch_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [DATA_W-1:0] wr_data_o;
    logic [ADDR_W-1:0] tbl_addr_o;
    logic [DATA_W-1:0] tbl_data_i;

    // The sequencer drives the request side and samples ready and table data.
    modport master (
        output wr_valid_o,
        output wr_ch_o,
        output wr_addr_o,
        output wr_data_o,
        output tbl_addr_o,
        input  wr_ready_i,
        input  tbl_data_i
    );

    // The storage and table side sees the mirror image.
    modport slave (
        input  wr_valid_o,
        input  wr_ch_o,
        input  wr_addr_o,
        input  wr_data_o,
        input  tbl_addr_o,
        output wr_ready_i,
        output tbl_data_i
    );
endinterface

// File: rtl/init_sequencer.sv
// ----------------------------------------------------------------------------
// init_sequencer
//
// Purpose:
//   Post-reset initialisation engine. It sweeps NUM_CH storage channels in
//   order, from channel 0 up to NUM_CH-1. For every address of every channel
//   it issues one write through a valid/ready port. The write data depends on
//   the channel mode:
//     0 = zero, 1 = address index, 2 = external table, 3 = FILL_VAL.
//   The block owns the arrays' write ports until done_o rises. A start_i pulse
//   in DONE runs a full re-initialisation without a reset.
//
// Configuration macro:
//   INIT_SEQ_AUTOSTART_EN
//     Defined:   the sweep starts on the first edge after reset release.
//     Undefined: the block waits in IDLE for start_i.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_i    in   asynchronous active-high reset
//   start_i  in   single-cycle start / re-init request (ignored while running)
//   wr_if    master modport of init_sequencer_if (write port + table lookup)
//   busy_o   out  sweep in progress
//   done_o   out  all channels initialised
// ----------------------------------------------------------------------------
module init_sequencer #(
    parameter int                          NUM_CH   = 4,
    parameter int                          ADDR_W   = 8,
    parameter int                          DATA_W   = 40,
    parameter logic [NUM_CH*(ADDR_W+1)-1:0] CH_DEPTH = {9'd27, 9'd32, 9'd256, 9'd256},
    parameter logic [NUM_CH*2-1:0]          CH_MODE  = {2'd2, 2'd1, 2'd0, 2'd0},
    parameter logic [DATA_W-1:0]            FILL_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             start_i,
    init_sequencer_if.master wr_if,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DEPTH_W = ADDR_W + 1;

    localparam logic [1:0] MODE_ZERO  = 2'd0;
    localparam logic [1:0] MODE_INDEX = 2'd1;
    localparam logic [1:0] MODE_TABLE = 2'd2;

`ifdef INIT_SEQ_AUTOSTART_EN
    localparam logic AUTO_START = 1'b1;
`else
    localparam logic AUTO_START = 1'b0;
`endif

    // A bad channel count or channel depth is caught at elaboration time, so
    // a misconfigured instance never reaches synthesis.
    generate
        if (NUM_CH < 1 || NUM_CH > 8) begin : g_badNumCh
            $error("init_sequencer: NUM_CH must be in 1..8");
        end
        for (genvar g = 0; g < NUM_CH; g++) begin : g_depthCheck
            localparam int D = int'(CH_DEPTH[g*DEPTH_W +: DEPTH_W]);
            if (D < 1 || D > (1 << ADDR_W)) begin : g_badDepth
                $error("init_sequencer: CH_DEPTH entry out of range 1..2^ADDR_W");
            end
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [CH_W-1:0]     ch_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                autoPend_q;
    logic                wrValid_q;
    logic                busy_q;
    logic                done_q;

    logic [DEPTH_W-1:0]  depthCur;
    logic [1:0]          modeCur;
    logic [DEPTH_W-1:0]  lastAddr;
    logic                atLastAddr;
    logic                atLastCh;
    logic                writeFire;
    logic [ADDR_W-1:0]   addr_d;
    logic [CH_W-1:0]     ch_d;
    logic [DATA_W-1:0]   chData;

    // Look up the depth and the fill mode of the channel being swept. The
    // loop unrolls into a small mux over the packed parameter vectors.
    // Channel 0 sits at the LSB end of both vectors.
    always_comb begin
        depthCur = CH_DEPTH[DEPTH_W-1:0];
        modeCur  = CH_MODE[1:0];
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == CH_W'(i)) begin
                depthCur = CH_DEPTH[i*DEPTH_W +: DEPTH_W];
                modeCur  = CH_MODE[i*2 +: 2];
            end
        end
    end

    // The end-of-channel test runs one bit wider than the address. This way
    // a channel of depth 2^ADDR_W ends cleanly at the all-ones address, and
    // the counter never wraps through zero before the channel switch.
    assign lastAddr   = depthCur - DEPTH_W'(1);
    assign atLastAddr = ({1'b0, addr_q} == lastAddr);
    assign atLastCh   = (ch_q == CH_W'(NUM_CH - 1));
    assign writeFire  = wrValid_q & wr_if.wr_ready_i;
    assign addr_d     = addr_q + ADDR_W'(1);
    assign ch_d       = ch_q + CH_W'(1);

    // Build the write data from the current channel mode. Table mode passes
    // the combinational table data straight through. The table is addressed
    // with the same register as the write port, so the pair stays consistent
    // while a write is stalled.
    always_comb begin
        chData = '0;
        case (modeCur)
            MODE_ZERO:  chData = '0;
            MODE_INDEX: chData = DATA_W'(addr_q);
            MODE_TABLE: chData = wr_if.tbl_data_i;
            default:    chData = FILL_VAL;
        endcase
    end

    // Sequencer FSM.
    // IDLE waits for a start request or a pending auto-start. RUN steps
    // through addresses and channels on each accepted write. DONE parks with
    // done_o high until a new start_i request arrives.
    // valid, busy and done are registered state, so the write port is glitch
    // free. Reset clears everything asynchronously, which discards any
    // partial sweep.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            addr_q     <= '0;
            autoPend_q <= AUTO_START;
            wrValid_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i || autoPend_q) begin
                        state_q    <= RUN;
                        autoPend_q <= 1'b0;
                        ch_q       <= '0;
                        addr_q     <= '0;
                        wrValid_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                RUN: begin
                    if (writeFire) begin
                        if (atLastAddr) begin
                            if (atLastCh) begin
                                state_q   <= DONE;
                                wrValid_q <= 1'b0;
                                busy_q    <= 1'b0;
                                done_q    <= 1'b1;
                            end else begin
                                ch_q   <= ch_d;
                                addr_q <= '0;
                            end
                        end else begin
                            addr_q <= addr_d;
                        end
                    end
                end
                DONE: begin
                    if (start_i) begin
                        state_q   <= RUN;
                        ch_q      <= '0;
                        addr_q    <= '0;
                        wrValid_q <= 1'b1;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    wrValid_q <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    // The channel and address registers drive the port directly in every
    // state. The data is forced to zero whenever no write is offered, so
    // reset, IDLE and DONE all present a quiet bus.
    assign wr_if.wr_valid_o = wrValid_q;
    assign wr_if.wr_ch_o    = ch_q;
    assign wr_if.wr_addr_o  = addr_q;
    assign wr_if.tbl_addr_o = addr_q;
    assign wr_if.wr_data_o  = wrValid_q ? chData : '0;
    assign busy_o           = busy_q;
    assign done_o           = done_q;

endmodule

// File: tb/tb_init_sequencer.sv
// ----------------------------------------------------------------------------
// tb_init_sequencer
//
// Purpose:
//   Exercises two instances of init_sequencer:
//     - a default 4-channel instance;
//     - a 1-channel fill-mode instance.
//   The stimulus side pushes every expected write into a queue. A monitor pops
//   the queue on each accepted write and compares the popped entry.
//   The bench follows INIT_SEQ_AUTOSTART_EN in the same way as the design.
//
// Ports: none (top-level testbench).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_init_sequencer;

    localparam int NUM_CH  = 4;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 40;
    localparam int CH_W    = 2;
    localparam int SWEEP_N = 571;
    localparam logic [DATA_W-1:0] SMALL_FILL = 40'hA5A5A5A5A5;

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef struct packed {
        logic [1:0]        addr;
        logic [DATA_W-1:0] data;
    } wr2_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;
    logic rst2;
    logic start2;
    logic busy2;
    logic done2;

    int testsRun    = 0;
    int testsFailed = 0;
    int writesSeen  = 0;
    int writes2Seen = 0;

    wr_t  expQ[$];
    wr2_t exp2Q[$];

    init_sequencer_if #(.CH_W(CH_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    init_sequencer_if #(.CH_W(1), .ADDR_W(2), .DATA_W(DATA_W)) bus2 ();

    // Table contents seen by channel 3. Each entry is a distinct pattern
    // built from its address.
    function automatic logic [DATA_W-1:0] tblFunc(input logic [ADDR_W-1:0] a);
        return {8'hC3, 16'h0000, ~a, a};
    endfunction

    assign bus.tbl_data_i  = tblFunc(bus.tbl_addr_o);
    assign bus2.tbl_data_i = '0;

    init_sequencer dut (
        .clk     (clk),
        .rst_i   (rst),
        .start_i (start),
        .wr_if   (bus),
        .busy_o  (busy),
        .done_o  (done)
    );

    init_sequencer #(
        .NUM_CH   (1),
        .ADDR_W   (2),
        .DATA_W   (DATA_W),
        .CH_DEPTH (3'd4),
        .CH_MODE  (2'd3),
        .FILL_VAL (SMALL_FILL)
    ) dut2 (
        .clk     (clk),
        .rst_i   (rst2),
        .start_i (start2),
        .wr_if   (bus2),
        .busy_o  (busy2),
        .done_o  (done2)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor for the main instance. On every accepted write it
    // pops the next expected write and compares it. While a write is
    // stalled, it also checks that the write port holds the previous values.
    logic stallPrev = 1'b0;
    wr_t  stallVal;
    always @(negedge clk) begin : monitor
        wr_t cur;
        wr_t exp;
        cur.ch   = bus.wr_ch_o;
        cur.addr = bus.wr_addr_o;
        cur.data = bus.wr_data_o;
        if (stallPrev && bus.wr_valid_o) begin
            testsRun++;
            if (cur != stallVal) begin
                testsFailed++;
                $display("[TB] FAIL hold: got ch=%0d addr=%0d data=%h, expected ch=%0d addr=%0d data=%h",
                         cur.ch, cur.addr, cur.data, stallVal.ch, stallVal.addr, stallVal.data);
            end
        end
        if (bus.wr_valid_o && bus.wr_ready_i) begin
            testsRun++;
            writesSeen++;
            if (expQ.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL write: unexpected ch=%0d addr=%0d data=%h, expected no write",
                         cur.ch, cur.addr, cur.data);
            end else begin
                exp = expQ.pop_front();
                if (cur != exp || bus.tbl_addr_o != cur.addr) begin
                    testsFailed++;
                    $display("[TB] FAIL write: got ch=%0d addr=%0d data=%h tbl=%0d, expected ch=%0d addr=%0d data=%h",
                             cur.ch, cur.addr, cur.data, bus.tbl_addr_o, exp.ch, exp.addr, exp.data);
                end
            end
        end
        stallPrev = bus.wr_valid_o && !bus.wr_ready_i;
        stallVal  = cur;
    end

    // Scoreboard monitor for the single-channel fill-mode instance.
    always @(negedge clk) begin : monitor2
        wr2_t exp;
        if (bus2.wr_valid_o && bus2.wr_ready_i) begin
            testsRun++;
            writes2Seen++;
            if (exp2Q.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL small write: unexpected addr=%0d data=%h, expected no write",
                         bus2.wr_addr_o, bus2.wr_data_o);
            end else begin
                exp = exp2Q.pop_front();
                if (bus2.wr_addr_o != exp.addr || bus2.wr_data_o != exp.data || bus2.wr_ch_o != 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL small write: got ch=%0d addr=%0d data=%h, expected ch=0 addr=%0d data=%h",
                             bus2.wr_ch_o, bus2.wr_addr_o, bus2.wr_data_o, exp.addr, exp.data);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Expected order of one full sweep with the default parameters:
    //   ch0: 256 zeros
    //   ch1: 256 zeros
    //   ch2: 32 index values
    //   ch3: 27 table entries
    task automatic pushSweep();
        wr_t w;
        for (int a = 0; a < 256; a++) begin
            w.ch = 2'd0; w.addr = ADDR_W'(a); w.data = '0; expQ.push_back(w);
        end
        for (int a = 0; a < 256; a++) begin
            w.ch = 2'd1; w.addr = ADDR_W'(a); w.data = '0; expQ.push_back(w);
        end
        for (int a = 0; a < 32; a++) begin
            w.ch = 2'd2; w.addr = ADDR_W'(a); w.data = DATA_W'(a); expQ.push_back(w);
        end
        for (int a = 0; a < 27; a++) begin
            w.ch = 2'd3; w.addr = ADDR_W'(a); w.data = tblFunc(ADDR_W'(a)); expQ.push_back(w);
        end
    endtask

    // Single-cycle start pulse. It is called at posedge+1 and returns at
    // posedge+1, right after the edge that samples the pulse.
    task automatic applyStimulus();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Moves the main instance out of IDLE right after reset release. With
    // auto-start the next edge does it by itself. Otherwise the block must
    // first stay silent for 100 cycles, and then a start pulse is issued.
    task automatic kickOff();
`ifdef INIT_SEQ_AUTOSTART_EN
        @(posedge clk);
        #1;
`else
        int idleValid;
        idleValid = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (bus.wr_valid_o) idleValid++;
        end
        checkOutput("idle no valid", 64'(idleValid), 64'd0);
        applyStimulus();
`endif
    endtask

    // Counts edges, starting at 1 for the edge that left IDLE, until done_o
    // rises or the budget runs out. It can toggle ready each cycle, and it
    // can pulse start_i ahead of one chosen edge.
    task automatic waitDone(input int budget, input bit toggle, input int pulseAt, output int edges);
        edges = 1;
        while (!done && edges < budget) begin
            start = (edges == pulseAt);
            @(posedge clk);
            #1;
            start = 1'b0;
            edges++;
            if (toggle) bus.wr_ready_i = ~bus.wr_ready_i;
        end
        if (!done) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL done timeout: got done=0 after %0d edges, expected done=1", edges);
        end
    endtask

    task automatic checkSweepEnd(input string tag);
        checkOutput({tag, " writes"}, 64'(writesSeen), 64'(SWEEP_N));
        checkOutput({tag, " queue empty"}, 64'(expQ.size()), 64'd0);
        checkOutput({tag, " busy low"}, 64'(busy), 64'd0);
        checkOutput({tag, " valid low"}, 64'(bus.wr_valid_o), 64'd0);
    endtask

    initial begin
        int edges;
        int n;
        bit found;
        rst            = 1'b1;
        rst2           = 1'b1;
        start          = 1'b0;
        start2         = 1'b0;
        bus.wr_ready_i  = 1'b1;
        bus2.wr_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        checkOutput("reset valid", 64'(bus.wr_valid_o), 64'd0);
        checkOutput("reset busy",  64'(busy), 64'd0);
        checkOutput("reset done",  64'(done), 64'd0);
        checkOutput("reset ch",    64'(bus.wr_ch_o), 64'd0);
        checkOutput("reset addr",  64'(bus.wr_addr_o), 64'd0);
        checkOutput("reset data",  64'(bus.wr_data_o), 64'd0);
        checkOutput("reset small valid", 64'(bus2.wr_valid_o), 64'd0);

        // First sweep with ready held high. A start pulse in the middle of
        // RUN must change neither the order nor the timing.
        pushSweep();
        rst = 1'b0;
        kickOff();
        checkOutput("first valid", 64'(bus.wr_valid_o), 64'd1);
        checkOutput("first busy",  64'(busy), 64'd1);
        waitDone(2000, 1'b0, 100, edges);
        checkOutput("sweep1 done edge", 64'(edges), 64'(SWEEP_N + 1));
        checkSweepEnd("sweep1");

        // DONE parks, and the address registers keep showing the last write.
        repeat (5) @(posedge clk);
        #1;
        checkOutput("done holds", 64'(done), 64'd1);
        checkOutput("done ch",    64'(bus.wr_ch_o), 64'd3);
        checkOutput("done addr",  64'(bus.wr_addr_o), 64'd26);
        checkOutput("done data",  64'(bus.wr_data_o), 64'd0);

        // Re-trigger from DONE, with backpressure toggling every cycle.
        writesSeen = 0;
        pushSweep();
        applyStimulus();
        checkOutput("retrig done low", 64'(done), 64'd0);
        checkOutput("retrig valid",    64'(bus.wr_valid_o), 64'd1);
        checkOutput("retrig ch",       64'(bus.wr_ch_o), 64'd0);
        checkOutput("retrig addr",     64'(bus.wr_addr_o), 64'd0);
        waitDone(3000, 1'b1, -1, edges);
        checkOutput("retrig done", 64'(done), 64'd1);
        checkSweepEnd("retrig");
        bus.wr_ready_i = 1'b1;

        // Reset pulse at ch2 addr 10. The partial sweep is dropped, and a full
        // sweep follows the release.
        writesSeen = 0;
        pushSweep();
        applyStimulus();
        n = 0;
        found = 1'b0;
        while (!found && n < 2000) begin
            @(negedge clk);
            n++;
            found = (bus.wr_ch_o == 2'd2 && bus.wr_addr_o == 8'd10 && bus.wr_valid_o);
        end
        checkOutput("reach ch2 addr10", 64'(found), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst valid", 64'(bus.wr_valid_o), 64'd0);
        checkOutput("midrst busy",  64'(busy), 64'd0);
        checkOutput("midrst done",  64'(done), 64'd0);
        checkOutput("midrst ch",    64'(bus.wr_ch_o), 64'd0);
        checkOutput("midrst addr",  64'(bus.wr_addr_o), 64'd0);
        checkOutput("midrst data",  64'(bus.wr_data_o), 64'd0);
        expQ.delete();
        pushSweep();
        @(posedge clk);
        #1;
        writesSeen = 0;
        rst = 1'b0;
        kickOff();
        checkOutput("resume ch",   64'(bus.wr_ch_o), 64'd0);
        checkOutput("resume addr", 64'(bus.wr_addr_o), 64'd0);
        waitDone(2000, 1'b0, -1, edges);
        checkOutput("resume done edge", 64'(edges), 64'(SWEEP_N + 1));
        checkSweepEnd("resume");

        // Single-channel fill-mode instance: four writes of FILL_VAL, and
        // done_o on the fifth edge.
        for (int a = 0; a < 4; a++) begin
            wr2_t w;
            w.addr = 2'(a);
            w.data = SMALL_FILL;
            exp2Q.push_back(w);
        end
        rst2 = 1'b0;
`ifdef INIT_SEQ_AUTOSTART_EN
        @(posedge clk);
        #1;
`else
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
`endif
        checkOutput("small first valid", 64'(bus2.wr_valid_o), 64'd1);
        edges = 1;
        while (!done2 && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checkOutput("small done edge", 64'(edges), 64'd5);
        checkOutput("small done", 64'(done2), 64'd1);
        checkOutput("small writes", 64'(writes2Seen), 64'd4);
        checkOutput("small queue empty", 64'(exp2Q.size()), 64'd0);
        checkOutput("small busy low", 64'(busy2), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
